// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the execute-stage multiply/divide unit.
package mdu_pkg;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // All divide/remainder codes have funct3[2] set
  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input mdu_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_rs1(input mdu_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_rs2(input mdu_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding mux: x0 reads as zero, otherwise the lowest-index
// matching forwarding source wins, otherwise the register-file value is used.
module fwd_select #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_AW-1:0]         i_addr,
  input  logic [XLEN-1:0]           i_rf_data,
  input  logic [NUM_FWD-1:0]        i_fwd_valid,
  input  logic [NUM_FWD*REG_AW-1:0] i_fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   i_fwd_data,
  output logic [XLEN-1:0]           o_data
);

  // Scan from the oldest source down so the youngest match overrides last
  always_comb begin
    o_data = i_rf_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_fwd_valid[i] && (i_fwd_rd[i*REG_AW +: REG_AW] == i_addr)) begin
        o_data = i_fwd_data[i*XLEN +: XLEN];
      end
    end
    if (i_addr == '0) begin
      o_data = '0;
    end
  end

endmodule

// File: rtl/ex_mdu_stage.sv
// Execute-stage RV32M unit: operands are resolved through the forwarding
// network at accept, then an iterative shift-add multiplier or restoring
// divider runs one bit per cycle and the result is offered on out_valid/out_ready.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE, and
// result/rd_out stay constant while out_valid is 1 and out_ready is 0.
module ex_mdu_stage
  import mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                op,
  input  logic [REG_AW-1:0]         rs1_addr,
  input  logic [REG_AW-1:0]         rs2_addr,
  input  logic [XLEN-1:0]           rs1_data,
  input  logic [XLEN-1:0]           rs2_data,
  input  logic [REG_AW-1:0]         rd_in,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           result,
  output logic [REG_AW-1:0]         rd_out,
  output logic                      busy,
  output mdu_state_e                dbg_state
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e            r_state, w_state_next;
  mdu_op_e               r_op;
  logic [CW-1:0]         r_cnt;
  logic [2*XLEN-1:0]     r_acc;     // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]       r_opnd;    // multiplicand / divisor magnitude
  logic                  r_neg_q;   // negate product or quotient at the end
  logic                  r_neg_r;   // negate remainder at the end
  logic [XLEN-1:0]       r_result;
  logic [REG_AW-1:0]     r_rd;

  logic [XLEN-1:0]       w_op1, w_op2, w_mag1, w_mag2;
  mdu_op_e               w_op;
  logic                  w_s1, w_s2, w_accept, w_div0, w_ovf, w_last;
  logic [XLEN:0]         w_mul_sum, w_div_rem_sh, w_div_diff;
  logic [2*XLEN-1:0]     w_mul_next, w_div_next, w_acc_next, w_prod_fix;
  logic [XLEN-1:0]       w_quo, w_rem, w_final;

  fwd_select #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .i_addr(rs1_addr), .i_rf_data(rs1_data), .i_fwd_valid(fwd_valid),
    .i_fwd_rd(fwd_rd), .i_fwd_data(fwd_data), .o_data(w_op1)
  );

  fwd_select #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .i_addr(rs2_addr), .i_rf_data(rs2_data), .i_fwd_valid(fwd_valid),
    .i_fwd_rd(fwd_rd), .i_fwd_data(fwd_data), .o_data(w_op2)
  );

  assign w_op     = mdu_op_e'(op);
  assign w_accept = in_valid && (r_state == IDLE) && !flush;
  assign w_s1     = is_signed_rs1(w_op) && w_op1[XLEN-1];
  assign w_s2     = is_signed_rs2(w_op) && w_op2[XLEN-1];
  assign w_mag1   = w_s1 ? -w_op1 : w_op1;
  assign w_mag2   = w_s2 ? -w_op2 : w_op2;
  assign w_div0   = is_div(w_op) && (w_op2 == '0);
  assign w_ovf    = ((w_op == OP_DIV) || (w_op == OP_REM)) && (w_op1 == SMIN) && (w_op2 == '1);
  assign w_last   = (r_cnt == CW'(1));

  // One iteration of multiply or divide plus the end-of-op sign fix-up
  always_comb begin
    w_mul_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_next   = {w_mul_sum, r_acc[XLEN-1:1]};
    w_div_rem_sh = r_acc[2*XLEN-1:XLEN-1];
    w_div_diff   = w_div_rem_sh - {1'b0, r_opnd};
    w_div_next   = w_div_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                    : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    w_acc_next   = is_div(r_op) ? w_div_next : w_mul_next;
    w_prod_fix   = r_neg_q ? -w_acc_next : w_acc_next;
    w_quo        = w_acc_next[XLEN-1:0];
    w_rem        = w_acc_next[2*XLEN-1:XLEN];
    w_final      = w_prod_fix[2*XLEN-1:XLEN];
    case (r_op)
      OP_MUL:           w_final = w_acc_next[XLEN-1:0];
      OP_DIV, OP_DIVU:  w_final = r_neg_q ? -w_quo : w_quo;
      OP_REM, OP_REMU:  w_final = r_neg_r ? -w_rem : w_rem;
      default:          w_final = w_prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_state_next = (w_div0 || w_ovf) ? DONE : CALC;
        CALC:    if (w_last) w_state_next = DONE;
        DONE:    if (out_ready) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Operand capture at accept, iteration in CALC, result registration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= OP_MUL;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_rd     <= '0;
    end else if (w_accept) begin
      r_op    <= w_op;
      r_rd    <= rd_in;
      r_cnt   <= CW'(XLEN);
      r_acc   <= {{XLEN{1'b0}}, w_mag1};
      r_opnd  <= w_mag2;
      r_neg_q <= w_s1 ^ w_s2;
      r_neg_r <= w_s1;
      if (w_div0)     r_result <= is_rem(w_op) ? w_op1 : '1;
      else if (w_ovf) r_result <= is_rem(w_op) ? '0 : SMIN;
    end else if ((r_state == CALC) && !flush) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) r_result <= w_final;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign result    = r_result;
  assign rd_out    = r_rd;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ex_mdu_stage.sv
// Self-checking bench for ex_mdu_stage: directed RV32M corner cases,
// forwarding priority, backpressure, flush, async reset and random ops
// compared against an arithmetic reference model.
module tb_ex_mdu_stage;
  import mdu_pkg::*;

  localparam int XLEN = 32;
  localparam int NF   = 2;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]      op;
  logic [AW-1:0]   rs1_addr, rs2_addr, rd_in, rd_out;
  logic [XLEN-1:0] rs1_data, rs2_data, result;
  logic [NF-1:0]   fwd_valid;
  logic [NF*AW-1:0]   fwd_rd;
  logic [NF*XLEN-1:0] fwd_data;
  mdu_state_e      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_acc = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [AW-1:0]   exp_rd_q[$];

  ex_mdu_stage #(.XLEN(XLEN), .NUM_FWD(NF), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_in(rd_in), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .rd_out(rd_out), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / cycle counter / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no end, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference model: operand resolution
  function automatic logic [XLEN-1:0] ref_operand(input logic [AW-1:0] a, input logic [XLEN-1:0] rf,
      input logic [NF-1:0] fv, input logic [NF*AW-1:0] frd, input logic [NF*XLEN-1:0] fd);
    if (a == 0) return 0;
    for (int i = 0; i < NF; i++)
      if (fv[i] && frd[i*AW +: AW] == a) return fd[i*XLEN +: XLEN];
    return rf;
  endfunction

  // Reference model: RV32M arithmetic using wide signed integers
  function automatic logic [XLEN-1:0] ref_result(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic signed [63:0] ea, eb, p;
    logic [31:0] ua, ub;
    ua = a; ub = b;
    if (f < 4) begin
      ea = (f == 1 || f == 2) ? {{32{a[31]}}, a} : {32'd0, a};
      eb = (f == 1) ? {{32{b[31]}}, b} : {32'd0, b};
      p = ea * eb;
      return (f == 0) ? p[31:0] : p[63:32];
    end
    if (b == 0) return (f == 4 || f == 5) ? 32'hFFFF_FFFF : a;
    if (f == 4 || f == 6) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (f == 4) ? a : 32'd0;
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
      p = (f == 4) ? ea / eb : ea % eb;
      return p[31:0];
    end
    return (f == 5) ? ua / ub : ua % ub;
  endfunction

  // Driver: present one op for one accept edge; leaves time at accept edge + 1
  task automatic issue(input logic [2:0] f, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
      input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2, input logic [AW-1:0] rd,
      input logic [NF-1:0] fv, input logic [NF*AW-1:0] frd, input logic [NF*XLEN-1:0] fd,
      input bit expect_out);
    logic [XLEN-1:0] o1, o2;
    @(negedge clk);
    op = f; rs1_addr = a1; rs2_addr = a2; rs1_data = d1; rs2_data = d2; rd_in = rd;
    fwd_valid = fv; fwd_rd = frd; fwd_data = fd; in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1'b1);
    o1 = ref_operand(a1, d1, fv, frd, fd);
    o2 = ref_operand(a2, d2, fv, frd, fd);
    if (expect_out) begin
      exp_q.push_back(ref_result(f, o1, o2));
      exp_rd_q.push_back(rd);
    end
    @(posedge clk); #1;
    t_acc = cyc;
    in_valid = 1'b0;
    fwd_valid = '0;
  endtask

  task automatic issue_simple(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
      input logic [AW-1:0] rd, input bit expect_out);
    issue(f, 5'd1, 5'd2, a, b, rd, '0, '0, '0, expect_out);
  endtask

  // Scoreboard: wait for out_valid, compare, optionally stall, then hand off
  task automatic wait_result(input int exp_lat, input int stall);
    int budget;
    logic [XLEN-1:0] exp_r, held;
    logic [AW-1:0] exp_rd;
    budget = 0;
    while (!out_valid && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    check("out_valid_timeout", out_valid, 1'b1);
    if (!out_valid) return;
    if (exp_lat > 0) check("latency", cyc - t_acc + 1, exp_lat);
    exp_r = exp_q.pop_front();
    exp_rd = exp_rd_q.pop_front();
    check("result", result, exp_r);
    check("rd_out", rd_out, exp_rd);
    held = result;
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("stall_out_valid", out_valid, 1'b1);
        check("stall_result", result, held);
        check("stall_rd_out", rd_out, exp_rd);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_busy", busy, 1'b1);
      end
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("out_valid_after_handoff", out_valid, 1'b0);
    check("in_ready_after_handoff", in_ready, 1'b1);
  endtask

  initial begin
    bit seen;
    logic [2:0] f;
    logic [XLEN-1:0] a, b;
    int st;

    rst = 1'b1; in_valid = 0; flush = 0; out_ready = 1; op = 0;
    rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0; rd_in = 0;
    fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, 0);
    check("rst_rd_out", rd_out, 0);
    check("rst_state", dbg_state, IDLE);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // MUL with exact latency, busy while calculating
    issue_simple(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1);
    check("calc_busy", busy, 1'b1);
    check("calc_in_ready", in_ready, 1'b0);
    wait_result(XLEN + 1, 0);

    // high-half multiplies
    issue_simple(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 1); wait_result(XLEN + 1, 0);
    issue_simple(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1); wait_result(XLEN + 1, 0);
    issue_simple(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1); wait_result(XLEN + 1, 0);

    // division special cases and signed rounding
    issue_simple(3'd4, 32'h1234_5678, 32'd0, 5'd7, 1); wait_result(1, 0);
    issue_simple(3'd6, 32'h1234_5678, 32'd0, 5'd8, 1); wait_result(1, 0);
    issue_simple(3'd5, 32'h1234_5678, 32'd0, 5'd8, 1); wait_result(1, 0);
    issue_simple(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1); wait_result(1, 0);
    issue_simple(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1); wait_result(1, 0);
    issue_simple(3'd4, -32'sd7, 32'd2, 5'd11, 1); wait_result(XLEN + 1, 0);
    issue_simple(3'd6, -32'sd7, 32'd2, 5'd12, 1); wait_result(XLEN + 1, 0);

    // forwarding priority: fwd0 beats fwd1 beats register file
    issue(3'd0, 5'd5, 5'd2, 32'hCC, 32'd1, 5'd13, 2'b11, {5'd5, 5'd5}, {32'hBB, 32'hAA}, 1);
    wait_result(XLEN + 1, 0);
    // fwd1 alone supplies rs2
    issue(3'd0, 5'd1, 5'd9, 32'd3, 32'd100, 5'd13, 2'b10, {5'd9, 5'd5}, {32'h11, 32'hAA}, 1);
    wait_result(XLEN + 1, 0);
    // x0 is zero even when a forwarding source matches
    issue(3'd0, 5'd0, 5'd2, 32'hCC, 32'd5, 5'd14, 2'b01, {5'd0, 5'd0}, {32'hBB, 32'hAA}, 1);
    wait_result(XLEN + 1, 0);
    // changing forwarding inputs after accept has no effect
    issue(3'd5, 5'd5, 5'd2, 32'hCC, 32'd3, 5'd15, 2'b01, {5'd0, 5'd5}, {32'h0, 32'h9999}, 1);
    @(negedge clk);
    fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_data = {32'h1, 32'h1};
    wait_result(XLEN + 1, 0);
    fwd_valid = '0;

    // backpressure, then an immediate new op
    out_ready = 1'b0;
    issue_simple(3'd1, 32'h7654_3210, 32'hDEAD_BEEF, 5'd16, 1);
    wait_result(XLEN + 1, 5);
    issue_simple(3'd7, 32'd100, 32'd7, 5'd17, 1); wait_result(XLEN + 1, 0);

    // flush during a DIVU: never presented
    issue_simple(3'd5, 32'hFFFF_0000, 32'd3, 5'd18, 0);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("flush_never_valid", seen, 1'b0);

    // flush coinciding with in_valid in IDLE drops the op
    @(negedge clk); in_valid = 1; flush = 1; op = 3'd0; rs1_addr = 1; rs2_addr = 2;
    @(posedge clk); #1; in_valid = 0; flush = 0;
    check("flush_drop_busy", busy, 1'b0);

    // async reset mid-CALC
    issue_simple(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd19, 0);
    repeat (4) @(posedge clk);
    #1; rst = 1'b1; #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_result", result, 0);
    check("arst_rd_out", rd_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1 check("arst_no_result", out_valid, 1'b0);

    // random ops against the reference model
    for (int n = 0; n < 40; n++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      st = $urandom_range(0, 3);
      if (st > 0) out_ready = 1'b0;
      issue_simple(f, a, b, 5'($urandom_range(1, 31)), 1);
      wait_result(-1, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_mdu_stage.md
Name: ex_mdu_stage

Overview:
Parametrised execute-stage multiply/divide unit implementing the RV32M operations.
- Resolves both operands through an N-source forwarding network at issue.
- Runs an iterative 1-bit/cycle shift-add multiplier or restoring divider.
- Returns the result to EX/MEM through a valid/ready handshake.
- Sits beside the single-cycle ALU/BRU path. Its busy output drives the hazard unit's EX stall.

Parameters:
XLEN, 32, datapath width in bits (even, >=8)
NUM_FWD, 2, number of forwarding sources; index 0 is the youngest and has the highest priority
REG_AW, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  ID/EX presents an M-op
in_ready  out  1  unit can accept
op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_addr, rs2_addr  in  REG_AW each  source register indices
rs1_data, rs2_data  in  XLEN each  register-file read data
rd_in  in  REG_AW  destination register
fwd_valid  in  NUM_FWD  per-source RegWrite
fwd_rd  in  NUM_FWD*REG_AW  per-source destination, source i at slice i
fwd_data  in  NUM_FWD*XLEN  per-source write data
flush  in  1  kill the in-flight op (branch mispredict)
out_valid  out  1  result available
out_ready  in  1  EX/MEM accepts
result  out  XLEN  op result
rd_out  out  REG_AW  destination of result
busy  out  1  state != IDLE

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE. out_valid, result, rd_out, busy and the internal counter/accumulators are all 0.
- Operand resolution, applied at acceptance (in_valid && in_ready):
  - If the source address is 0, the operand is 0.
  - Otherwise the lowest index i with fwd_valid[i] and fwd_rd[i] equal to the address supplies fwd_data[i].
  - Otherwise the operand is rs*_data.
  - The resolved operands and rd_in are registered; later changes on the fwd inputs are ignored.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On accept, check special cases first:
    - DIV/DIVU/REM/REMU with divisor 0: quotient all-ones, remainder = dividend. Go to DONE; out_valid rises at T+1.
    - DIV/REM with dividend = signed min and divisor = -1: quotient = signed min, remainder 0. Go to DONE.
    - All other ops: go to CALC with counter = XLEN.
- CALC:
  - Performs one iteration per cycle and decrements the counter.
  - Signed ops work on magnitudes, with sign flags captured at accept:
    - MULH: both operands signed.
    - MULHSU: rs1 signed only.
    - MUL, MULHU, DIVU, REMU: unsigned.
  - The product accumulator is 2*XLEN bits. MUL returns the low half; the MULH variants return the high half after conditional two's-complement negation of the full product.
  - Division is restoring. Quotient sign = s1 xor s2; remainder sign = s1.
  - The iteration with counter==1 also applies the sign fix-up and registers result. State goes to DONE.
  - out_valid rises at T+XLEN+1 (T = accept cycle).
- DONE:
  - out_valid=1. result and rd_out are held stable while out_ready=0.
  - On out_ready, go to IDLE; out_valid falls the next cycle.
  - in_ready=0 in CALC and DONE, so there is no same-cycle re-accept; the next accept is possible the cycle after handoff.
- flush: synchronous, highest priority over every other event.
  - In any state, the next state is IDLE and out_valid=0 the next cycle. The result is never presented.
  - A flush coinciding with in_valid in IDLE drops that input.
  - A flush coinciding with the out_valid/out_ready handshake still completes that handoff, because the consumer has already sampled the result.
- Reset asserted mid-CALC aborts immediately. No partial result ever appears.
- busy is combinational from state. The hazard unit stalls IF/ID/EX while busy or out_valid&&!out_ready.
- All arithmetic is XLEN-generic. There are no 32-bit literals; signed min is 1 followed by XLEN-1 zeros.

Decomposition:
- Package mdu_pkg holds:
  - enum mdu_op_e (8 funct3 codes)
  - enum mdu_state_e {IDLE, CALC, DONE}
  - helper functions is_div(op) and is_signed_rs1/rs2(op)
- Sub-module fwd_select (parameters XLEN, REG_AW, NUM_FWD) is a priority forwarding mux. It is instantiated once per operand and replaces the fixed 2-source mux.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, out_ready=1 -> result 0xFFFFFFEB, out_valid exactly at T+33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV 0x12345678/0 -> 0xFFFFFFFF at T+1. REM same operands -> 0x12345678. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. DIV -7/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
- Forwarding:
  - rs1_addr=5, fwd0 {1,5,0xAA}, fwd1 {1,5,0xBB}, rs1_data=0xCC -> fwd0 value 0xAA used.
  - rs1_addr=0 with fwd0 {1,0,0xAA} matching -> operand 0.
  - Changing fwd_data after accept does not alter the result.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> result/rd_out stable, in_ready=0, busy=1. Handoff then IDLE; a new op is accepted the following cycle.
- flush at T+10 of a DIVU -> no out_valid ever for that op, in_ready=1 at T+11. Async rst at T+5 -> all outputs 0 immediately.
